// File: rtl/instruction_fetch.sv
// Stage-0 instruction fetch: one memory request/ready handshake per stage-0 visit,
// with misaligned PCs and memory timeouts resolved to a NOP plus a fault pulse.
module instruction_fetch #(
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] NOP     = 32'h00000013
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  stage,
    input  logic [31:0] PC,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] instruction,
    output logic        fetch_done,
    output logic        fault,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last WAIT cycle index; a response on this cycle still wins over the timeout.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;

    logic stage_zero;
    assign stage_zero = (stage == 2'd0);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= 32'd0;
            instr_q <= NOP;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stage_zero) begin
                    if (PC[1:0] != 2'b00) begin
                        instr_d = NOP;
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = PC;
                        req_d   = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Stays here even if stage leaves 0; the sequencer must not do that.
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    instr_d = NOP;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                if (!stage_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign stall       = ((state_q == ST_IDLE) && stage_zero) || (state_q == ST_WAIT);
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instruction = instr_q;
    assign fetch_done  = done_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a queue of expected fetch results.
module tb_instruction_fetch;

    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        CLK;
    logic        Reset;
    logic [1:0]  stage;
    logic [31:0] PC;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instruction;
    logic        fetch_done;
    logic        fault;
    logic        stall;

    typedef struct {
        logic [31:0] instr;
        logic        done;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   req_cycles;

    instruction_fetch #(.TIMEOUT(4), .NOP(NOP_W)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .stage(stage),
        .PC(PC),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .instruction(instruction),
        .fetch_done(fetch_done),
        .fault(fault),
        .stall(stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic done, input logic flt);
        exp_t e;
        e.instr = instr;
        e.done  = done;
        e.flt   = flt;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            $display("txn %s: instr=%h done=%b fault=%b (exp %h/%b/%b)",
                     tag, instruction, fetch_done, fault, e.instr, e.done, e.flt);
            chk({tag, "_instr"}, instruction, e.instr);
            chk({tag, "_done"}, 32'(fetch_done), 32'(e.done));
            chk({tag, "_fault"}, 32'(fault), 32'(e.flt));
        end
    endtask

    initial begin
        Reset = 1'b1; stage = 2'd1; PC = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_instr", instruction, NOP_W);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Aligned fetch, ready one cycle after the request.
        stage = 2'd0; PC = 32'h00000010;
        #1 chk("f1_stall_idle", 32'(stall), 32'd1);
        push_exp(32'h00500093, 1'b1, 1'b0);
        tick();
        chk("f1_req", 32'(mem_req), 32'd1);
        chk("f1_addr", mem_addr, 32'h10);
        chk("f1_stall_wait", 32'(stall), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ready = 1'b0;
        sb_check("fetch1");
        chk("f1_req_drop", 32'(mem_req), 32'd0);
        chk("f1_stall_done", 32'(stall), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(fetch_done), 32'd0);
        chk("f1_no_refetch", 32'(mem_req), 32'd0);
        stage = 2'd1;
        tick();

        // Misaligned PC: NOP and fault, no request.
        stage = 2'd0; PC = 32'h00000006;
        push_exp(NOP_W, 1'b0, 1'b1);
        tick();
        sb_check("misalign");
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        stage = 2'd1;
        tick();
        chk("mis_fault_pulse", 32'(fault), 32'd0);

        // Ready arrives on the last timeout cycle: ready wins.
        stage = 2'd0; PC = 32'h00000030;
        push_exp(32'hdeadbeef, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("last_req_held", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hdeadbeef;
        tick();
        mem_ready = 1'b0;
        sb_check("ready_last");
        stage = 2'd1;
        tick();

        // Timeout with ready held low; PC moves mid-wait.
        stage = 2'd0; PC = 32'h00000020;
        push_exp(NOP_W, 1'b0, 1'b1);
        tick();
        chk("to_addr", mem_addr, 32'h20);
        PC = 32'h00000044;
        req_cycles = 0;
        while (mem_req && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", 32'(req_cycles), 32'd4);
        sb_check("timeout");
        chk("to_addr_stable", mem_addr, 32'h20);
        stage = 2'd1;
        tick();

        // Load a non-NOP word, then reset in the 2nd WAIT cycle of the next fetch.
        stage = 2'd0; PC = 32'h00000040;
        push_exp(32'h00000073, 1'b1, 1'b0);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h00000073;
        tick();
        mem_ready = 1'b0;
        sb_check("pre_reset");
        stage = 2'd1;
        tick();
        stage = 2'd0; PC = 32'h00000050;
        tick();
        tick();
        Reset = 1'b1; stage = 2'd1;
        tick();
        Reset = 1'b0;
        chk("wrst_req", 32'(mem_req), 32'd0);
        chk("wrst_instr", instruction, NOP_W);
        mem_ready = 1'b1; mem_rdata = 32'h0badc0de;
        tick();
        mem_ready = 1'b0;
        chk("wrst_ignored_instr", instruction, NOP_W);
        chk("wrst_ignored_done", 32'(fetch_done), 32'd0);
        chk("wrst_left", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
